// File: rtl/ram_burst_reader_if.sv
// ram_burst_reader_if
//   Bundles the command, RAM read-port and output-stream signals of
//   ram_burst_reader.
//   master : the burst reader itself (drives busy/done, RAM address/enable,
//            and the stream data/valid/last).
//   slave  : the surroundings (command source, RAM, stream sink).
//   Signals:
//     start/start_addr/length : burst command, sampled on start in IDLE
//     busy/done               : burst status
//     ram_raddr/ram_re        : to RAM read port
//     ram_rdata               : from RAM read port
//     m_data/m_valid/m_last   : output stream
//     m_ready                 : stream back-pressure from the sink
interface ram_burst_reader_if #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 9,
  parameter int LEN_WIDTH  = ADDR_WIDTH + 1
);
  logic                  start;
  logic [ADDR_WIDTH-1:0] start_addr;
  logic [LEN_WIDTH-1:0]  length;
  logic                  busy;
  logic                  done;
  logic [ADDR_WIDTH-1:0] ram_raddr;
  logic                  ram_re;
  logic [DATA_WIDTH-1:0] ram_rdata;
  logic [DATA_WIDTH-1:0] m_data;
  logic                  m_valid;
  logic                  m_ready;
  logic                  m_last;

  modport master (
    input  start, start_addr, length, ram_rdata, m_ready,
    output busy, done, ram_raddr, ram_re, m_data, m_valid, m_last
  );

  modport slave (
    output start, start_addr, length, ram_rdata, m_ready,
    input  busy, done, ram_raddr, ram_re, m_data, m_valid, m_last
  );
endinterface

// File: rtl/ram_burst_reader.sv
// ram_burst_reader
//   Read-side controller for the simple dual-port RAM. A start command
//   streams `length` consecutive words (address wrapping at the top of
//   memory) out on a valid/ready stream. Reads are throttled by a 4-credit
//   rule so that every word ever requested from the RAM has a guaranteed
//   slot in the 4-entry first-word-fall-through skid FIFO; the sink may
//   stall at any time without loss or duplication.
//   Ports:
//     clk  : single clock (RAM rclk is tied to it)
//     rst  : asynchronous, active-high reset
//     bus  : ram_burst_reader_if.master (command, status, RAM read port,
//            output stream)
//   OUTPUT_REG must match the attached RAM: "FALSE" -> 1-cycle read
//   latency, "TRUE" -> 2-cycle read latency.
module ram_burst_reader #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 9,
  parameter     OUTPUT_REG = "FALSE",
  parameter int LEN_WIDTH  = ADDR_WIDTH + 1
) (
  input  logic               clk,
  input  logic               rst,
  ram_burst_reader_if.master bus
);

  localparam int LAT        = (OUTPUT_REG == "TRUE") ? 2 : 1;
  localparam int STAGES     = LAT - 1;
  localparam int FIFO_DEPTH = 4;

  typedef enum logic [1:0] {IDLE, READ, DRAIN} state_t;

  typedef struct packed {
    logic                  last;
    logic [DATA_WIDTH-1:0] data;
  } beat_t;

  state_t                state, state_nxt;

  // burst bookkeeping
  logic [ADDR_WIDTH-1:0] addr;
  logic [LEN_WIDTH-1:0]  remaining;

  // registered RAM request
  logic                  ram_re_q;
  logic                  ram_last_q;
  logic [ADDR_WIDTH-1:0] ram_raddr_q;

  // latency tracker: vld_pipe[STAGES] is high exactly when ram_rdata holds
  // a requested word; last_pipe travels alongside it
  logic [STAGES:0]       vld_pipe;
  logic [STAGES:0]       last_pipe;

  // skid FIFO
  beat_t                 fifo_mem [FIFO_DEPTH];
  logic [1:0]            wr_ptr, rd_ptr;
  logic [2:0]            fifo_count;
  beat_t                 head;
  logic                  push, pop, m_valid_c;

  // credit accounting
  logic [2:0]            inflight;
  logic [3:0]            credit_used;

  // FSM outputs
  logic                  issue;
  logic                  busy_c;
  logic                  done_nxt;
  logic                  done_q;

  assign m_valid_c = (fifo_count != 3'd0);
  assign head      = fifo_mem[rd_ptr];
  assign pop       = m_valid_c & bus.m_ready;
  assign push      = vld_pipe[STAGES];

  // Every word that is requested but not yet accepted by the sink occupies
  // one credit: the pending request, each tracker stage, and each FIFO
  // entry. A pop on this edge frees its slot before the new request lands,
  // which keeps the stream bubble-free at full rate for both latencies.
  always_comb begin
    inflight = {2'b00, ram_re_q};
    for (int i = 0; i <= STAGES; i++) begin
      inflight = inflight + {2'b00, vld_pipe[i]};
    end
    credit_used = {1'b0, fifo_count} + {1'b0, inflight} - {3'b000, pop};
  end

  // ---------------------------------------------------------------- FSM
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (bus.start && (bus.length != '0)) state_nxt = READ;
      // remaining reaches zero on the edge that registers the final request;
      // leaving READ one edge later keeps ram_re confined to READ
      READ:    if (remaining == '0) state_nxt = DRAIN;
      DRAIN:   if (pop && head.last) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    busy_c   = (state != IDLE);
    issue    = (state == READ) && (remaining != '0) && (credit_used < 4'd4);
    done_nxt = ((state == IDLE)  && bus.start && (bus.length == '0)) ||
               ((state == DRAIN) && pop && head.last);
  end

  // ---------------------------------------------------------- datapath
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      addr        <= '0;
      remaining   <= '0;
      ram_re_q    <= 1'b0;
      ram_last_q  <= 1'b0;
      ram_raddr_q <= '0;
      vld_pipe    <= '0;
      last_pipe   <= '0;
      done_q      <= 1'b0;
    end else begin
      done_q <= done_nxt;
      if ((state == IDLE) && bus.start) begin
        addr      <= bus.start_addr;
        remaining <= bus.length;
      end else if (issue) begin
        addr      <= addr + 1'b1;          // wraps MAX -> 0
        remaining <= remaining - 1'b1;
      end
      ram_re_q   <= issue;
      ram_last_q <= issue && (remaining == LEN_WIDTH'(1));
      if (issue) ram_raddr_q <= addr;
      vld_pipe[0]  <= ram_re_q;
      last_pipe[0] <= ram_last_q;
      for (int i = 1; i <= STAGES; i++) begin
        vld_pipe[i]  <= vld_pipe[i-1];
        last_pipe[i] <= last_pipe[i-1];
      end
    end
  end

  // ------------------------------------------------------------- FIFO
  always_ff @(posedge clk) begin
    if (push) fifo_mem[wr_ptr] <= '{last: last_pipe[STAGES], data: bus.ram_rdata};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   fifo_count <= fifo_count + 1'b1;
        2'b01:   fifo_count <= fifo_count - 1'b1;
        default: fifo_count <= fifo_count;
      endcase
    end
  end

  fifo_no_overflow: assert property (@(posedge clk) disable iff (rst)
    !(push && !pop && (fifo_count == 3'(FIFO_DEPTH))));

  // ----------------------------------------------------------- outputs
  assign bus.busy      = busy_c;
  assign bus.done      = done_q;
  assign bus.ram_re    = ram_re_q;
  assign bus.ram_raddr = ram_raddr_q;
  assign bus.m_valid   = m_valid_c;
  // gated so stale FIFO contents never show while empty (including after reset)
  assign bus.m_data    = m_valid_c ? head.data : '0;
  assign bus.m_last    = m_valid_c & head.last;

endmodule
